// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch controller: hazard stall sequencing, ID-compare forwarding, PC redirect, statistics.
// Jumps and hazard-free branches redirect in the same cycle; dependent branches stall 1-2 cycles before resolving.
module branch_hazard_ctrl #(
   parameter int AW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [1:0]       id_ctrl,
   input  logic             id_jump,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             cmp,
   input  logic [AW-1:0]    br_target,
   input  logic [AW-1:0]    j_target,
   input  logic             ex_wr,
   input  logic             ex_ld,
   input  logic [4:0]       ex_rd,
   input  logic             mem_wr,
   input  logic             mem_ld,
   input  logic [4:0]       mem_rd,
   input  logic             wb_wr,
   input  logic [4:0]       wb_rd,
   input  logic             flush_in,
   output logic             stall,
   output logic             bubble_ex,
   output logic             pc_sel,
   output logic [AW-1:0]    pc_target,
   output logic             flush_ifid,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] tk_cnt,
   output logic [CNT_W-1:0] st_cnt
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HOLD    = 2'd1,
      RESOLVE = 2'd2
   } state_t;

   typedef struct packed {
      logic       wr;
      logic       ld;
      logic [4:0] rd;
   } wdest_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   state_t           state, next_state;
   logic [1:0]       hold_cnt, next_hold;
   logic [CNT_W-1:0] br_q, tk_q, st_q;

   wdest_t     ex_dst, mem_dst, wb_dst;
   logic [1:0] haz_a, haz_b, haz_max;
   logic       br_run, jump_act, hold_act, resolve_act, taken;

   assign ex_dst  = {ex_wr, ex_ld, ex_rd};
   assign mem_dst = {mem_wr, mem_ld, mem_rd};
   assign wb_dst  = {wb_wr, 1'b0, wb_rd};

   function automatic logic src_match(input logic [4:0] src, input wdest_t d);
      return (src != 5'd0) && d.wr && (d.rd == src);
   endfunction

   // Cycles until the operand can be forwarded into the ID comparator.
   function automatic logic [1:0] hazard_of(input logic [4:0] src, input wdest_t ex,
                                            input wdest_t mem);
      if (src_match(src, ex))
         return ex.ld ? 2'd2 : 2'd1;
      if (src_match(src, mem) && mem.ld)
         return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src, input wdest_t mem,
                                          input wdest_t wb);
      if (src_match(src, mem) && !mem.ld)
         return FWD_MEM;
      if (src_match(src, wb))
         return FWD_WB;
      return FWD_RF;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign haz_a   = hazard_of(id_rs, ex_dst, mem_dst);
   assign haz_b   = hazard_of(id_rt, ex_dst, mem_dst);
   assign haz_max = (haz_a > haz_b) ? haz_a : haz_b;
   assign taken   = cmp ~^ id_ctrl[0];

   // A jump shadows any branch flag and skips the hazard check entirely.
   assign br_run      = (state == RUN) && id_valid && id_ctrl[1] && !id_jump;
   assign jump_act    = (state == RUN) && id_valid && id_jump && !flush_in;
   assign hold_act    = (state == HOLD) && !flush_in;
   assign resolve_act = !flush_in &&
                        ((br_run && (haz_max == 2'd0)) || (state == RESOLVE));

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= RUN;
         hold_cnt <= 2'd0;
      end else begin
         state    <= next_state;
         hold_cnt <= next_hold;
      end
   end

   always_comb begin
      next_state = state;
      next_hold  = hold_cnt;
      if (flush_in) begin
         next_state = RUN;
         next_hold  = 2'd0;
      end else begin
         case (state)
            RUN: begin
               if (br_run && (haz_max != 2'd0)) begin
                  next_state = HOLD;
                  next_hold  = haz_max - 2'd1;
               end
            end
            HOLD: begin
               if (hold_cnt == 2'd0)
                  next_state = RESOLVE;
               else
                  next_hold = hold_cnt - 2'd1;
            end
            RESOLVE: next_state = RUN;
            default: begin
               next_state = RUN;
               next_hold  = 2'd0;
            end
         endcase
      end
   end

   always_comb begin
      stall      = 1'b0;
      bubble_ex  = 1'b0;
      pc_sel     = 1'b0;
      flush_ifid = 1'b0;
      pc_target  = '0;
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
      if (reset_n) begin
         stall      = hold_act;
         bubble_ex  = hold_act;
         pc_sel     = jump_act | (resolve_act & taken);
         flush_ifid = jump_act | (resolve_act & taken);
         pc_target  = ((state == RUN) && id_jump) ? j_target : br_target;
         if (resolve_act) begin
            fwd_a = fwd_sel(id_rs, mem_dst, wb_dst);
            fwd_b = fwd_sel(id_rt, mem_dst, wb_dst);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         br_q <= '0;
         tk_q <= '0;
         st_q <= '0;
      end else begin
         if (resolve_act) begin
            br_q <= sat_inc(br_q);
            if (taken)
               tk_q <= sat_inc(tk_q);
         end
         if (hold_act)
            st_q <= sat_inc(st_q);
      end
   end

   assign br_cnt = reset_n ? br_q : '0;
   assign tk_cnt = reset_n ? tk_q : '0;
   assign st_cnt = reset_n ? st_q : '0;

endmodule
